// File: rtl/mdu_control.sv
// Multiply/divide sequencer for the MIPS EX stage: iterative radix-2 multiply, restoring divide, HI/LO.
// Optional build macro MDU_FAST_MUL_EN: single-cycle multiply; divide stays iterative.
module mdu_control #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            alu_code_in,
    input  logic [5:0]            ist_code_in,
    input  logic                  issue_valid,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  md_busy,
    output logic                  stall_out,
    output logic                  mf_valid,
    output logic [DATA_WIDTH-1:0] mf_data,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int W = DATA_WIDTH;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    // acc_hi holds product-high / partial remainder; acc_lo holds multiplier / dividend-then-quotient.
    logic [W-1:0]         acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [W-1:0]         opa_q, opa_d, opb_q, opb_d;
    logic                 div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;

    logic         mdu_funct, issued, op_signed;
    logic [W-1:0] abs_a, abs_b;
    logic [W:0]   rem_shift, div_diff;
    logic [2*W-1:0] prod_raw, prod_fix;
    logic [W-1:0] quo_fix, rem_fix;

    assign mdu_funct = (ist_code_in[5:2] == 4'b0100) || (ist_code_in[5:2] == 4'b0110);
    assign issued    = issue_valid && (alu_code_in == 2'b10) && mdu_funct && !flush;
    assign op_signed = !ist_code_in[0];
    assign abs_a     = (op_signed && src_a[W-1]) ? -src_a : src_a;
    assign abs_b     = (op_signed && src_b[W-1]) ? -src_b : src_b;

    assign rem_shift = {acc_hi_q, acc_lo_q[W-1]};
    assign div_diff  = rem_shift - {1'b0, opb_q};

    assign prod_raw  = {acc_hi_q, acc_lo_q};
    assign prod_fix  = neg_q ? -prod_raw : prod_raw;
    assign quo_fix   = neg_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix   = rneg_q ? -acc_hi_q : acc_hi_q;

`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_prod;
    assign fast_prod = {{W{1'b0}}, acc_lo_q} * {{W{1'b0}}, opb_q};
`else
    logic [W:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {W{1'b0}})};
`endif

    assign md_busy   = (state_q != S_IDLE);
    assign stall_out = md_busy && issued;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

    always_comb begin
        mf_valid = 1'b0;
        mf_data  = '0;
        if (!md_busy && issued && ((ist_code_in == F_MFHI) || (ist_code_in == F_MFLO))) begin
            mf_valid = 1'b1;
            mf_data  = (ist_code_in == F_MFHI) ? hi_q : lo_q;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        div_d    = div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        unique case (state_q)
            S_IDLE: begin
                if (issued) begin
                    unique case (ist_code_in)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            state_d  = ist_code_in[1] ? S_DIV : S_MUL;
                            div_d    = ist_code_in[1];
                            cnt_d    = CNT_LOAD;
                            acc_hi_d = '0;
                            acc_lo_d = abs_a;
                            opa_d    = src_a;
                            opb_d    = abs_b;
                            neg_d    = op_signed && (src_a[W-1] ^ src_b[W-1]);
                            rneg_d   = op_signed && src_a[W-1];
                        end
                        F_MTHI:  hi_d = src_a;
                        F_MTLO:  lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
`ifdef MDU_FAST_MUL_EN
                    {acc_hi_d, acc_lo_d} = fast_prod;
                    state_d = S_FIN;
`else
                    acc_hi_d = mul_sum[W:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = S_FIN;
`endif
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!div_diff[W]) begin
                        acc_hi_d = div_diff[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_shift[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!flush) begin
                    if (!div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (opb_q == '0) begin
                        hi_d = opa_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

endmodule

// File: tb/tb_mdu_control.sv
// Directed self-checking bench for mdu_control (builds with or without MDU_FAST_MUL_EN).
module tb_mdu_control;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int FLUSH_AT = 1;
`else
    localparam int MUL_LAT  = 33;
    localparam int FLUSH_AT = 10;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  alu_code_in;
    logic [5:0]  ist_code_in;
    logic        issue_valid;
    logic        flush;
    logic [31:0] src_a, src_b;
    logic        md_busy, stall_out, mf_valid;
    logic [31:0] mf_data, hi_out, lo_out;

    int checks = 0;
    int errors = 0;

    mdu_control #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .alu_code_in (alu_code_in),
        .ist_code_in (ist_code_in),
        .issue_valid (issue_valid),
        .flush       (flush),
        .src_a       (src_a),
        .src_b       (src_b),
        .md_busy     (md_busy),
        .stall_out   (stall_out),
        .mf_valid    (mf_valid),
        .mf_data     (mf_data),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        alu_code_in = 2'b10;
        ist_code_in = f;
        src_a       = a;
        src_b       = b;
    endtask

    task automatic idle_in();
        issue_valid = 1'b0;
        alu_code_in = 2'b00;
        ist_code_in = 6'd0;
        src_a       = 32'd0;
        src_b       = 32'd0;
    endtask

    // Issue one op for one cycle, then count busy cycles until the result lands.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        drive(f, a, b);
        step();
        idle_in();
        lat = 0;
        while (md_busy && lat < 100) begin
            lat++;
            step();
        end
    endtask

    task automatic test_reset();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset md_busy got %b want 0", md_busy); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset stall_out got %b want 0", stall_out); end
        checks++; if (mf_valid !== 1'b0) begin errors++; $display("FAIL reset mf_valid got %b want 0", mf_valid); end
        checks++; if (mf_data !== 32'd0) begin errors++; $display("FAIL reset mf_data got %h want 0", mf_data); end
        checks++; if (hi_out !== 32'd0) begin errors++; $display("FAIL reset hi got %h want 0", hi_out); end
        checks++; if (lo_out !== 32'd0) begin errors++; $display("FAIL reset lo got %h want 0", lo_out); end
    endtask

    task automatic test_op(input string name, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        run_op(f, a, b, lat);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        checks++; if (hi_out !== exp_hi) begin errors++; $display("FAIL %s hi got %h want %h", name, hi_out, exp_hi); end
        checks++; if (lo_out !== exp_lo) begin errors++; $display("FAIL %s lo got %h want %h", name, lo_out, exp_lo); end
    endtask

    task automatic test_mt_mf();
        drive(F_MTHI, 32'hA5A5A5A5, 32'd0);
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL mthi stall got %b want 0", stall_out); end
        step();
        drive(F_MFHI, 32'd0, 32'd0);
        #1;
        checks++; if (mf_valid !== 1'b1) begin errors++; $display("FAIL mfhi valid got %b want 1", mf_valid); end
        checks++; if (mf_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL mfhi data got %h want a5a5a5a5", mf_data); end
        step();
        drive(F_MTLO, 32'h12345678, 32'd0);
        step();
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        checks++; if (mf_data !== 32'h12345678) begin errors++; $display("FAIL mflo data got %h want 12345678", mf_data); end
        alu_code_in = 2'b01;
        #1;
        checks++; if (mf_valid !== 1'b0) begin errors++; $display("FAIL non-rtype mf_valid got %b want 0", mf_valid); end
        step();
        idle_in();
    endtask

    task automatic test_stall_mf();
        int  stall_cnt;
        logic bad;
        drive(F_DIV, 32'd100, 32'd7);
        step();
        idle_in();
        repeat (2) step();
        drive(F_ADDU, 32'd1, 32'd2);
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL addu stall got %b want 0", stall_out); end
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div busy got %b want 1", md_busy); end
        step();
        idle_in();
        step();
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        stall_cnt = 0;
        bad = 1'b0;
        while (md_busy && stall_cnt < 100) begin
            if (stall_out !== 1'b1 || mf_valid !== 1'b0) bad = 1'b1;
            stall_cnt++;
            step();
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mflo stall while busy got bad=%b want 0", bad); end
        checks++; if (stall_cnt !== 29) begin errors++; $display("FAIL mflo stall cycles got %0d want 29", stall_cnt); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL mflo stall after idle got %b want 0", stall_out); end
        checks++; if (mf_valid !== 1'b1) begin errors++; $display("FAIL mflo valid after idle got %b want 1", mf_valid); end
        checks++; if (mf_data !== 32'd14) begin errors++; $display("FAIL mflo data got %h want e", mf_data); end
        checks++; if (hi_out !== 32'd2) begin errors++; $display("FAIL div rem got %h want 2", hi_out); end
        step();
        idle_in();
    endtask

    task automatic test_flush();
        drive(F_MTHI, 32'd5, 32'd0);
        step();
        drive(F_MTLO, 32'd5, 32'd0);
        step();
        drive(F_MULT, 32'd3, 32'd4);
        step();
        idle_in();
        repeat (FLUSH_AT - 1) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL flush busy got %b want 0", md_busy); end
        repeat (40) step();
        checks++; if (hi_out !== 32'd5) begin errors++; $display("FAIL flush hi got %h want 5", hi_out); end
        checks++; if (lo_out !== 32'd5) begin errors++; $display("FAIL flush lo got %h want 5", lo_out); end
        // Flush landing on the final cycle must suppress the write.
        drive(F_MULTU, 32'd9, 32'd9);
        step();
        idle_in();
        repeat (MUL_LAT - 1) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (lo_out !== 32'd5) begin errors++; $display("FAIL flush-fin lo got %h want 5", lo_out); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL flush-fin busy got %b want 0", md_busy); end
        // Issue together with flush is dropped.
        drive(F_MULTU, 32'd9, 32'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL flush-issue busy got %b want 0", md_busy); end
    endtask

    task automatic test_reset_mid();
        drive(F_DIV, 32'hFFFFFFF9, 32'd2);
        step();
        idle_in();
        repeat (5) step();
        resetn = 1'b0;
        #2;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL async reset busy got %b want 0", md_busy); end
        checks++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin errors++; $display("FAIL async reset hi/lo got %h/%h want 0/0", hi_out, lo_out); end
        checks++; if (stall_out !== 1'b0 || mf_valid !== 1'b0 || mf_data !== 32'd0) begin errors++; $display("FAIL async reset stall/mfv/mfd got %b/%b/%h want 0", stall_out, mf_valid, mf_data); end
        resetn = 1'b1;
        repeat (3) step();
        checks++; if (md_busy !== 1'b0 || lo_out !== 32'd0) begin errors++; $display("FAIL post reset busy/lo got %b/%h want 0/0", md_busy, lo_out); end
    endtask

    initial begin
        resetn = 1'b0;
        flush  = 1'b0;
        idle_in();
        #2;
        test_reset();
        step();
        resetn = 1'b1;
        step();
        test_op("multu", F_MULTU, 32'hFFFFFFFF, 32'h2, MUL_LAT, 32'h1, 32'hFFFFFFFE);
        test_op("mult", F_MULT, 32'hFFFFFFFD, 32'd7, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);
        test_op("div", F_DIV, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_op("divu0", F_DIVU, 32'd100, 32'd0, DIV_LAT, 32'd100, 32'hFFFFFFFF);
        test_op("divmin", F_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'd0, 32'h80000000);
        test_op("divu", F_DIVU, 32'hFFFFFFFF, 32'h10, DIV_LAT, 32'hF, 32'h0FFFFFFF);
        test_mt_mf();
        test_stall_mf();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
